// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the rv_fetch instruction fetch unit.
// Holds data widths, PC step, default reset vector and the FIFO entry type.
package rv_fetch_pkg;
    localparam int          INSTR_W          = 32;
    localparam int          PC_W             = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] ir;
    } fetch_entry_t;

    // PCs are always word aligned; the low two address bits are dropped.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/rv_fetch_if.sv
// Fetch-unit bus: instruction memory request/response plus decode/execute side.
// master = fetch unit, slave = the environment (memory, decode, execute).
interface rv_fetch_if;
    import rv_fetch_pkg::*;

    logic                f_stall_i;
    logic                x_jump_i;
    logic [PC_W-1:0]     x_jump_target_i;
    logic [PC_W-1:0]     im_addr_o;
    logic                im_rd_o;
    logic [INSTR_W-1:0]  im_data_i;
    logic                im_valid_i;
    logic [INSTR_W-1:0]  f_ir_o;
    logic [PC_W-1:0]     f_pc_o;
    logic                f_valid_o;

    modport master (
        input  f_stall_i, x_jump_i, x_jump_target_i, im_data_i, im_valid_i,
        output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
    );

    modport slave (
        output f_stall_i, x_jump_i, x_jump_target_i, im_data_i, im_valid_i,
        input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
    );
endinterface

// File: rtl/rv_fetch_fifo.sv
// Two-entry {pc, ir} FIFO between the memory response path and decode.
// Head is read straight from the storage registers; flush empties it in one cycle.
module rv_fetch_fifo
    import rv_fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);
    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only accepted alongside a pop of the head.
    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && !i_flush && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch unit: keeps up to two words in flight or buffered, discards
// responses belonging to a redirected stream, and feeds decode from a small FIFO.
module rv_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
)(
    input  logic       clk_i,
    input  logic       rst_n_i,
    rv_fetch_if.master bus
);
    logic [PC_W-1:0] r_req_pc;
    logic [PC_W-1:0] r_rsp_pc;
    logic [1:0]      r_outst;
    logic [1:0]      r_discard;

    logic            w_valid;
    logic            w_pop;
    logic            w_issue;
    logic            w_rsp_acc;
    logic            w_push;
    logic            w_empty;
    logic            w_full;
    logic [1:0]      w_count;
    logic [2:0]      w_inflight;
    logic [PC_W-1:0] w_jump_pc;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    assign w_valid   = rst_n_i && !w_empty;
    assign w_pop     = w_valid && !bus.f_stall_i && !bus.x_jump_i;
    assign w_jump_pc = pc_align(bus.x_jump_target_i);

    // Requests in flight plus buffered words never exceed the FIFO depth.
    assign w_inflight = {1'b0, r_outst} + {1'b0, w_count} - {2'b00, w_pop};
    assign w_issue    = rst_n_i && !bus.x_jump_i && (w_inflight < 3'd2);

    assign w_rsp_acc = bus.im_valid_i && (r_outst != 2'd0);
    assign w_push    = w_rsp_acc && (r_discard == 2'd0) && !bus.x_jump_i
                       && (!w_full || w_pop);

    assign w_push_data.pc = r_rsp_pc;
    assign w_push_data.ir = bus.im_data_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_req_pc  <= RESET_VECTOR;
            r_rsp_pc  <= RESET_VECTOR;
            r_outst   <= 2'd0;
            r_discard <= 2'd0;
        end else begin
            case ({w_issue, w_rsp_acc})
                2'b10:   r_outst <= r_outst + 2'd1;
                2'b01:   r_outst <= r_outst - 2'd1;
                default: r_outst <= r_outst;
            endcase

            if (bus.x_jump_i) begin
                // Everything still in flight belongs to the old stream.
                r_req_pc  <= w_jump_pc;
                r_rsp_pc  <= w_jump_pc;
                r_discard <= w_rsp_acc ? (r_outst - 2'd1) : r_outst;
            end else begin
                if (w_issue) r_req_pc <= r_req_pc + PC_INC;
                if (w_push)  r_rsp_pc <= r_rsp_pc + PC_INC;
                if (w_rsp_acc && (r_discard != 2'd0)) r_discard <= r_discard - 2'd1;
            end
        end
    end

    rv_fetch_fifo u_fifo (
        .i_clk       (clk_i),
        .i_rst_n     (rst_n_i),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (bus.x_jump_i),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign bus.im_addr_o = r_req_pc;
    assign bus.im_rd_o   = w_issue;
    assign bus.f_valid_o = w_valid;
    assign bus.f_ir_o    = w_head.ir;
    assign bus.f_pc_o    = w_head.pc;
endmodule

// File: tb/tb_rv_fetch.sv
// Directed and randomised bench for rv_fetch with an in-order variable-latency memory model.
module tb_rv_fetch;
    import rv_fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv_fetch_if bus();

    rv_fetch #(.RESET_VECTOR(RV)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic        drv_rst_n, drv_stall, drv_jump, drv_spurious;
    logic [31:0] drv_tgt;
    int          mem_lat;
    bit          mem_rand;

    logic [31:0] q_addr [$];
    int          q_due  [$];
    int          last_due;

    logic        s_rd, s_valid, s_mem_valid;
    logic [31:0] s_addr, s_pc, s_ir;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: drive inputs at negedge, sample outputs, then model memory at posedge.
    task automatic step();
        int lat;
        int due;
        @(negedge clk);
        rst_n               = drv_rst_n;
        bus.f_stall_i       = drv_stall;
        bus.x_jump_i        = drv_jump;
        bus.x_jump_target_i = drv_tgt;
        s_mem_valid         = 1'b0;
        if (!drv_rst_n) begin
            q_addr.delete();
            q_due.delete();
            last_due       = 0;
            bus.im_valid_i = 1'b0;
            bus.im_data_i  = 32'h0;
        end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            bus.im_valid_i = 1'b1;
            bus.im_data_i  = mem_data(q_addr[0]);
            s_mem_valid    = 1'b1;
        end else if (drv_spurious) begin
            bus.im_valid_i = 1'b1;
            bus.im_data_i  = 32'hDEAD_BEEF;
        end else begin
            bus.im_valid_i = 1'b0;
            bus.im_data_i  = $urandom;
        end
        #1;
        s_rd    = bus.im_rd_o;
        s_addr  = bus.im_addr_o;
        s_valid = bus.f_valid_o;
        s_pc    = bus.f_pc_o;
        s_ir    = bus.f_ir_o;
        @(posedge clk);
        if (s_mem_valid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (s_rd === 1'b1) begin
            lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            due = cyc + 1 + lat;
            if (due <= last_due) due = last_due + 1;
            q_addr.push_back(s_addr);
            q_due.push_back(due);
            last_due = due;
        end
        cyc++;
    endtask

    task automatic idle_inputs();
        drv_stall    = 1'b0;
        drv_jump     = 1'b0;
        drv_tgt      = 32'h0;
        drv_spurious = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        drv_rst_n = 1'b0;
        step();
        drv_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_rand  = 1'b0;
        mem_lat   = 0;
        drv_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid c%0d: got %b want 0", i, s_valid); end
            vectors++; if (s_rd !== 1'b0)    begin errors++; $display("FAIL reset_rd c%0d: got %b want 0", i, s_rd); end
        end
        drv_rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors++; if (s_rd !== 1'b1) begin errors++; $display("FAIL seq_rd c%0d: got %b want 1", c, s_rd); end
            vectors++; if (s_addr !== RV + 32'(4 * c)) begin errors++; $display("FAIL seq_addr c%0d: got %h want %h", c, s_addr, RV + 32'(4 * c)); end
            vectors++; if (s_valid !== (c >= 2)) begin errors++; $display("FAIL seq_valid c%0d: got %b want %b", c, s_valid, c >= 2); end
            if (c >= 2) begin
                exp_pc = RV + 32'(4 * (c - 2));
                vectors++; if (s_pc !== exp_pc) begin errors++; $display("FAIL seq_pc c%0d: got %h want %h", c, s_pc, exp_pc); end
                vectors++; if (s_ir !== mem_data(exp_pc)) begin errors++; $display("FAIL seq_ir c%0d: got %h want %h", c, s_ir, mem_data(exp_pc)); end
            end
        end
    endtask

    task automatic test_stall();
        drv_stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            vectors++; if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_valid s%0d: got %b want 1", s, s_valid); end
            vectors++; if (s_pc !== 32'h118) begin errors++; $display("FAIL stall_pc s%0d: got %h want 00000118", s, s_pc); end
            vectors++; if (s_rd !== 1'b0) begin errors++; $display("FAIL stall_rd s%0d: got %b want 0", s, s_rd); end
        end
        drv_stall = 1'b0;
        for (int r = 0; r < 4; r++) begin
            step();
            vectors++; if (s_pc !== 32'h118 + 32'(4 * r)) begin errors++; $display("FAIL release_pc r%0d: got %h want %h", r, s_pc, 32'h118 + 32'(4 * r)); end
            vectors++; if (s_ir !== mem_data(32'h118 + 32'(4 * r))) begin errors++; $display("FAIL release_ir r%0d: got %h", r, s_ir); end
            vectors++; if (s_rd !== 1'b1 || s_addr !== 32'h120 + 32'(4 * r)) begin errors++; $display("FAIL release_req r%0d: got rd=%b addr=%h want rd=1 addr=%h", r, s_rd, s_addr, 32'h120 + 32'(4 * r)); end
        end
    endtask

    task automatic test_jump_outstanding();
        do_reset();
        mem_lat = 3;
        step();
        vectors++; if (s_rd !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL jo_req0: got rd=%b addr=%h want 1/00000100", s_rd, s_addr); end
        step();
        vectors++; if (s_rd !== 1'b1 || s_addr !== 32'h104) begin errors++; $display("FAIL jo_req1: got rd=%b addr=%h want 1/00000104", s_rd, s_addr); end
        mem_lat  = 0;
        drv_jump = 1'b1;
        drv_tgt  = 32'h2000;
        step();
        vectors++; if (s_rd !== 1'b0) begin errors++; $display("FAIL jo_jump_rd: got %b want 0", s_rd); end
        idle_inputs();
        for (int j = 3; j < 7; j++) begin
            step();
            vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL jo_valid j%0d: got %b want 0", j, s_valid); end
            vectors++; if (s_rd !== (j >= 5)) begin errors++; $display("FAIL jo_rd j%0d: got %b want %b", j, s_rd, j >= 5); end
            if (j >= 5) begin
                vectors++; if (s_addr !== 32'h2000 + 32'(4 * (j - 5))) begin errors++; $display("FAIL jo_addr j%0d: got %h want %h", j, s_addr, 32'h2000 + 32'(4 * (j - 5))); end
            end
        end
        for (int j = 7; j < 9; j++) begin
            step();
            vectors++; if (s_valid !== 1'b1 || s_pc !== 32'h2000 + 32'(4 * (j - 7))) begin errors++; $display("FAIL jo_pc j%0d: got v=%b pc=%h want 1/%h", j, s_valid, s_pc, 32'h2000 + 32'(4 * (j - 7))); end
            vectors++; if (s_ir !== mem_data(32'h2000 + 32'(4 * (j - 7)))) begin errors++; $display("FAIL jo_ir j%0d: got %h", j, s_ir); end
        end
    endtask

    task automatic test_jump_stall_rsp();
        do_reset();
        mem_lat = 0;
        step();
        step();
        drv_stall = 1'b1;
        drv_jump  = 1'b1;
        drv_tgt   = 32'h3000;
        step();
        vectors++; if (s_valid !== 1'b1 || s_pc !== 32'h100) begin errors++; $display("FAIL js_head: got v=%b pc=%h want 1/00000100", s_valid, s_pc); end
        vectors++; if (s_rd !== 1'b0) begin errors++; $display("FAIL js_rd: got %b want 0", s_rd); end
        idle_inputs();
        step();
        vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL js_flush_valid: got %b want 0", s_valid); end
        vectors++; if (s_rd !== 1'b1 || s_addr !== 32'h3000) begin errors++; $display("FAIL js_req: got rd=%b addr=%h want 1/00003000", s_rd, s_addr); end
        step();
        vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL js_valid2: got %b want 0", s_valid); end
        step();
        vectors++; if (s_valid !== 1'b1 || s_pc !== 32'h3000) begin errors++; $display("FAIL js_pc: got v=%b pc=%h want 1/00003000", s_valid, s_pc); end
        vectors++; if (s_ir !== mem_data(32'h3000)) begin errors++; $display("FAIL js_ir: got %h want %h", s_ir, mem_data(32'h3000)); end
    endtask

    task automatic test_wrap_spurious();
        logic [31:0] exp_pc;
        do_reset();
        mem_lat  = 0;
        drv_jump = 1'b1;
        drv_tgt  = 32'hFFFF_FFFA;
        step();
        vectors++; if (s_rd !== 1'b0) begin errors++; $display("FAIL wr_jump_rd: got %b want 0", s_rd); end
        idle_inputs();
        drv_spurious = 1'b1;
        step();
        vectors++; if (s_rd !== 1'b1 || s_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wr_req0: got rd=%b addr=%h want 1/fffffff8", s_rd, s_addr); end
        drv_spurious = 1'b0;
        step();
        vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL wr_spurious_valid: got %b want 0", s_valid); end
        vectors++; if (s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_req1: got %h want fffffffc", s_addr); end
        for (int k = 0; k < 3; k++) begin
            step();
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            vectors++; if (s_valid !== 1'b1 || s_pc !== exp_pc) begin errors++; $display("FAIL wr_pc k%0d: got v=%b pc=%h want 1/%h", k, s_valid, s_pc, exp_pc); end
            vectors++; if (s_ir !== mem_data(exp_pc)) begin errors++; $display("FAIL wr_ir k%0d: got %h want %h", k, s_ir, mem_data(exp_pc)); end
            vectors++; if (s_addr !== 32'(4 * k)) begin errors++; $display("FAIL wr_addr k%0d: got %h want %h", k, s_addr, 32'(4 * k)); end
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        mem_lat = 0;
        step();
        step();
        drv_stall = 1'b1;
        for (int c = 2; c < 4; c++) begin
            step();
            vectors++; if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_rd !== 1'b0) begin errors++; $display("FAIL rf_fill c%0d: got v=%b pc=%h rd=%b want 1/00000100/0", c, s_valid, s_pc, s_rd); end
        end
        idle_inputs();
        drv_rst_n = 1'b0;
        step();
        vectors++; if (s_valid !== 1'b0 || s_rd !== 1'b0) begin errors++; $display("FAIL rf_in_reset: got v=%b rd=%b want 0/0", s_valid, s_rd); end
        drv_rst_n = 1'b1;
        step();
        vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rf_after_valid: got %b want 0", s_valid); end
        vectors++; if (s_rd !== 1'b1 || s_addr !== RV) begin errors++; $display("FAIL rf_restart: got rd=%b addr=%h want 1/%h", s_rd, s_addr, RV); end
        step();
        step();
        vectors++; if (s_valid !== 1'b1 || s_pc !== RV || s_ir !== mem_data(RV)) begin errors++; $display("FAIL rf_first: got v=%b pc=%h ir=%h want 1/%h/%h", s_valid, s_pc, s_ir, RV, mem_data(RV)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int          consumed;
        int          idle_cnt;
        bit          bad;
        do_reset();
        mem_rand = 1'b1;
        exp_pc   = RV;
        consumed = 0;
        idle_cnt = 0;
        bad      = 1'b0;
        for (int i = 0; i < 3000 && !bad; i++) begin
            drv_stall = ($urandom_range(0, 3) == 0);
            drv_jump  = ($urandom_range(0, 39) == 0);
            drv_tgt   = $urandom;
            step();
            if (s_valid === 1'b1) begin
                idle_cnt = 0;
                vectors++; if (s_pc !== exp_pc) begin errors++; bad = 1'b1; $display("FAIL rnd_pc i%0d: got %h want %h", i, s_pc, exp_pc); end
                vectors++; if (s_ir !== mem_data(exp_pc)) begin errors++; bad = 1'b1; $display("FAIL rnd_ir i%0d: got %h want %h", i, s_ir, mem_data(exp_pc)); end
            end else begin
                idle_cnt++;
            end
            vectors++; if (idle_cnt > 40) begin errors++; bad = 1'b1; $display("FAIL rnd_stuck i%0d: no valid for %0d cycles, want <= 40", i, idle_cnt); end
            if (drv_jump) exp_pc = {drv_tgt[31:2], 2'b00};
            else if (s_valid === 1'b1 && !drv_stall) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
        end
        idle_inputs();
        mem_rand = 1'b0;
        vectors++; if (consumed < 300) begin errors++; $display("FAIL rnd_throughput: got %0d consumed want >= 300", consumed); end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.f_stall_i       = 1'b0;
        bus.x_jump_i        = 1'b0;
        bus.x_jump_target_i = 32'h0;
        bus.im_data_i       = 32'h0;
        bus.im_valid_i      = 1'b0;
        drv_rst_n           = 1'b0;
        last_due            = 0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_jump_outstanding();
        test_jump_stall_rsp();
        test_wrap_spurious();
        test_reset_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
